// File: rtl/reg_serializer_pkg.sv
// Shared definitions for the register serializer: FSM encoding, default
// geometry and helpers that derive beat count and counter width.
package reg_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int unsigned DEF_BIT_LENGTH = 32;
    localparam int unsigned DEF_CHUNK      = 8;
    localparam int unsigned NBEATS         = DEF_BIT_LENGTH / DEF_CHUNK;
    localparam int unsigned CNT_W          = $clog2(NBEATS);

    // Beats needed to unload one word.
    function automatic int unsigned nbeats_f(input int unsigned bit_length,
                                             input int unsigned chunk);
        return bit_length / chunk;
    endfunction

    // Counter width; at least one bit even for degenerate geometries.
    function automatic int unsigned cnt_w_f(input int unsigned nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/reg_serializer_beat_counter.sv
// Beat counter: counts accepted beats 0..LAST, synchronous clear and
// enable, terminal-count flag while the count sits at LAST.
module beat_counter
    import reg_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W,
    parameter int unsigned LAST  = NBEATS - 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [WIDTH-1:0] LAST_C = WIDTH'(LAST);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST_C);

    // Next count: clear wins, and the count wraps at LAST so it never exceeds it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_serializer.sv
// Parallel-to-serial unloader: captures a BIT_LENGTH word on load and
// emits it CHUNK bits per beat, LSB chunk first, over a valid/ready link.
module reg_serializer
    import reg_serializer_pkg::*;
#(
    parameter int unsigned BIT_LENGTH = DEF_BIT_LENGTH,
    parameter int unsigned CHUNK      = DEF_CHUNK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIT_LENGTH-1:0] parIn,
    output logic [CHUNK-1:0]      outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  outLast,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NB = nbeats_f(BIT_LENGTH, CHUNK);
    localparam int unsigned CW = cnt_w_f(NB);

    generate
        if ((BIT_LENGTH % CHUNK) != 0 || NB < 2) begin : g_bad_geometry
            $error("reg_serializer: BIT_LENGTH must be a multiple of CHUNK with at least 2 beats");
        end
    endgenerate

    ser_state_e            state_q, state_d;
    logic [BIT_LENGTH-1:0] shreg_q, shreg_d;
    logic                  done_q,  done_d;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_tc;

    beat_counter #(
        .WIDTH (CW),
        .LAST  (NB - 1)
    ) u_beat_counter (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Next-state: capture on load in IDLE, shift out on each accepted beat.
    // load is only looked at in IDLE, so it cannot disturb a word in flight.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = parIn;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (outReady) begin
                    shreg_d = shreg_q >> CHUNK;
                    cnt_en  = 1'b1;
                    if (cnt_tc) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, shift register and done pulse; reset overrides load and transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers; the register is zero-filled as it
    // shifts, so outData reads 0 once a word has fully drained.
    assign outData  = shreg_q[CHUNK-1:0];
    assign outValid = (state_q == SHIFT);
    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign outLast  = (state_q == SHIFT) && cnt_tc;

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer (32-bit word, 8-bit beats): directed table,
// hand-written corner sequences and random traffic against a queue model.
module tb_reg_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] parIn = '0;
    logic [7:0]  outData;
    logic        outValid;
    logic        outReady = 1'b1;
    logic        outLast;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];   // beats still owed by the DUT, front = current
    logic       m_done = 1'b0;
    logic [7:0] got[$];  // beats actually transferred

    reg_serializer #(.BIT_LENGTH(32), .CHUNK(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .parIn    (parIn),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .outLast  (outLast),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One clock: log transfer, advance model, clock DUT, compare with model.
    task automatic cyc();
        if (!rst && outValid === 1'b1 && outReady) got.push_back(outData);
        if (rst) begin
            mq.delete();
            m_done = 1'b0;
        end else if (mq.size() > 0) begin
            m_done = 1'b0;
            if (outReady) begin
                void'(mq.pop_front());
                m_done = (mq.size() == 0);
            end
        end else begin
            m_done = 1'b0;
            if (load) for (int i = 0; i < 4; i++) mq.push_back(8'((parIn >> (8 * i)) & 32'hFF));
        end
        @(posedge clk);
        #1;
        chk("m_valid", {31'b0, outValid}, {31'b0, mq.size() > 0});
        chk("m_busy",  {31'b0, busy},     {31'b0, mq.size() > 0});
        chk("m_last",  {31'b0, outLast},  {31'b0, mq.size() == 1});
        chk("m_done",  {31'b0, done},     {31'b0, m_done});
        if (mq.size() > 0) chk("m_data", {24'b0, outData}, {24'b0, mq[0]});
    endtask

    task automatic expect_beat(input string nm, input logic [7:0] d, input logic last);
        chk({nm, "_valid"}, {31'b0, outValid}, 32'd1);
        chk({nm, "_data"},  {24'b0, outData},  {24'b0, d});
        chk({nm, "_last"},  {31'b0, outLast},  {31'b0, last});
    endtask

    typedef struct {
        logic [31:0] word;
        int          stall_at;
        int          stall_len;
        logic [7:0]  exp[4];
    } vec_t;

    vec_t vt[4];

    initial begin
        vt[0] = '{word: 32'h12345678, stall_at: 9, stall_len: 0, exp: '{8'h78, 8'h56, 8'h34, 8'h12}};
        vt[1] = '{word: 32'hDEADBEEF, stall_at: 1, stall_len: 2, exp: '{8'hEF, 8'hBE, 8'hAD, 8'hDE}};
        vt[2] = '{word: 32'h00FF00FF, stall_at: 0, stall_len: 3, exp: '{8'hFF, 8'h00, 8'hFF, 8'h00}};
        vt[3] = '{word: 32'h80000001, stall_at: 3, stall_len: 4, exp: '{8'h01, 8'h00, 8'h00, 8'h80}};

        // Reset for two cycles: every output 0.
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_data",  {24'b0, outData}, 32'd0);
        chk("rst_valid", {31'b0, outValid}, 32'd0);
        chk("rst_last",  {31'b0, outLast}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        rst = 1'b0;
        cyc();

        // Basic unload with outReady held high.
        parIn = 32'hA1B2C3D4; load = 1'b1; outReady = 1'b1;
        cyc();
        load = 1'b0;
        expect_beat("b0", 8'hD4, 1'b0); cyc();
        expect_beat("b1", 8'hC3, 1'b0); cyc();
        expect_beat("b2", 8'hB2, 1'b0); cyc();
        expect_beat("b3", 8'hA1, 1'b1); cyc();
        chk("basic_done", {31'b0, done}, 32'd1);
        chk("basic_busy", {31'b0, busy}, 32'd0);
        cyc();
        chk("basic_done_once", {31'b0, done}, 32'd0);

        // Backpressure: C3 held for three stalled cycles.
        got.delete();
        load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_beat("bp_hold", 8'hC3, 1'b0);
            cyc();
        end
        expect_beat("bp_after", 8'hC3, 1'b0);
        outReady = 1'b1;
        cyc(); cyc(); cyc();
        chk("bp_done", {31'b0, done}, 32'd1);
        chk("bp_count", got.size(), 32'd4);
        if (got.size() == 4) begin
            chk("bp_g0", {24'b0, got[0]}, 32'hD4);
            chk("bp_g1", {24'b0, got[1]}, 32'hC3);
            chk("bp_g2", {24'b0, got[2]}, 32'hB2);
            chk("bp_g3", {24'b0, got[3]}, 32'hA1);
        end
        cyc();

        // load held high with all-ones while shifting, including the last beat.
        parIn = 32'hA1B2C3D4; load = 1'b1;
        cyc();
        parIn = 32'hFFFFFFFF;
        expect_beat("ig0", 8'hD4, 1'b0); cyc();
        expect_beat("ig1", 8'hC3, 1'b0); cyc();
        expect_beat("ig2", 8'hB2, 1'b0); cyc();
        expect_beat("ig3", 8'hA1, 1'b1); cyc();
        load = 1'b0;
        chk("ig_busy", {31'b0, busy}, 32'd0);
        chk("ig_done", {31'b0, done}, 32'd1);
        cyc();

        // Reset after C3 transfers: word abandoned, no done pulse.
        parIn = 32'hA1B2C3D4; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc(); cyc();
        expect_beat("ra_b2", 8'hB2, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("ra_busy",  {31'b0, busy}, 32'd0);
        chk("ra_valid", {31'b0, outValid}, 32'd0);
        chk("ra_done",  {31'b0, done}, 32'd0);
        cyc();
        chk("ra_done2", {31'b0, done}, 32'd0);
        parIn = 32'h00000011; load = 1'b1;
        cyc();
        load = 1'b0;
        expect_beat("ra_n0", 8'h11, 1'b0); cyc();
        expect_beat("ra_n1", 8'h00, 1'b0); cyc();
        expect_beat("ra_n2", 8'h00, 1'b0); cyc();
        expect_beat("ra_n3", 8'h00, 1'b1); cyc();
        chk("ra_ndone", {31'b0, done}, 32'd1);
        cyc();

        // Table: words with a stall window, beats compared to the table.
        for (int v = 0; v < 4; v++) begin
            bit seen;
            got.delete();
            seen = 1'b0;
            parIn = vt[v].word; load = 1'b1; outReady = 1'b1;
            cyc();
            load = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                outReady = !(k >= vt[v].stall_at && k < vt[v].stall_at + vt[v].stall_len);
                cyc();
                if (done === 1'b1) seen = 1'b1;
            end
            outReady = 1'b1;
            chk($sformatf("tbl%0d_done_seen", v), {31'b0, seen}, 32'd1);
            chk($sformatf("tbl%0d_count", v), got.size(), 32'd4);
            for (int i = 0; i < 4 && i < got.size(); i++)
                chk($sformatf("tbl%0d_beat%0d", v, i), {24'b0, got[i]}, {24'b0, vt[v].exp[i]});
            cyc();
        end

        // Random traffic, checked every cycle against the queue model.
        for (int n = 0; n < 600; n++) begin
            load     = ($urandom % 3) == 0;
            parIn    = $urandom;
            outReady = ($urandom % 10) < 7;
            rst      = ($urandom % 60) == 0;
            cyc();
        end
        rst = 1'b0; load = 1'b0; outReady = 1'b1;
        for (int n = 0; n < 6; n++) cyc();
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
